// File: rtl/toggle_decoder.sv
// -----------------------------------------------------------------------------
// toggle_decoder
//
// Decodes a toggle-encoded serial line. The line toggles for a 1 bit and holds
// for a 0 bit. Decoded bits slide into an 8-bit shift register. In HUNT the
// register is searched for SYNC_WORD. In LOCKED every eight decoded bits form a
// byte, which is handed to a consumer through a valid/ready hold register with
// a sticky overrun flag. A run of IDLE_LIMIT cycles without a new bit while
// LOCKED drops the decoder back to HUNT.
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   line_in carries a new encoded bit this cycle
//   line_in    in   toggle-encoded line level
//   ready      in   consumer accepts data_out this cycle
//   ovr_clr    in   pulse that clears overrun
//   bit_out    out  registered decoded bit
//   bit_valid  out  bit_out is valid this cycle (one cycle after en)
//   data_out   out  assembled byte, first received bit in bit 0
//   data_valid out  data_out is held for the consumer
//   locked     out  decoder is in LOCKED
//   overrun    out  sticky: a completed byte was dropped
// -----------------------------------------------------------------------------
module toggle_decoder #(
  parameter logic [7:0]  SYNC_WORD  = 8'hA5,
  parameter int unsigned IDLE_LIMIT = 16     // legal range 1..255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       line_in,
  input  logic       ready,
  input  logic       ovr_clr,
  output logic       bit_out,
  output logic       bit_valid,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       locked,
  output logic       overrun
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Idle count value whose next en=0 cycle reaches IDLE_LIMIT.
  localparam logic [7:0] IDLE_LAST = 8'(IDLE_LIMIT - 1);

  state_e     state_q, state_d;
  logic       prev_line_q, prev_line_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] idle_cnt_q, idle_cnt_d;
  logic       bit_out_q, bit_out_d;
  logic       bit_valid_q, bit_valid_d;
  logic [7:0] data_out_q, data_out_d;
  logic       data_valid_q, data_valid_d;
  logic       locked_q, locked_d;
  logic       overrun_q, overrun_d;

  logic       dec_bit;
  logic       byte_done;
  logic       ovr_set;

  assign dec_bit = line_in ^ prev_line_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    prev_line_d  = prev_line_q;
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    bit_out_d    = bit_out_q;
    bit_valid_d  = 1'b0;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    byte_done    = 1'b0;
    ovr_set      = 1'b0;

    // Decode and slide the window; the newest bit enters at the MSB.
    if (en) begin
      prev_line_d = line_in;
      sr_d        = {dec_bit, sr_q[7:1]};
      bit_out_d   = dec_bit;
      bit_valid_d = 1'b1;
      idle_cnt_d  = '0;
    end

    case (state_q)
      HUNT: begin
        // Compare the window after this cycle's shift, not the old one.
        if (en && (sr_d == SYNC_WORD)) begin
          state_d   = LOCKED;
          bit_cnt_d = '0;
        end
      end
      LOCKED: begin
        if (en) begin
          // Counter wraps 7 -> 0 on the byte's last bit.
          bit_cnt_d = bit_cnt_q + 3'd1;
          byte_done = (bit_cnt_q == 3'd7);
        end else if (idle_cnt_q == IDLE_LAST) begin
          // Lock loss drops the partial byte; the held output byte stays.
          state_d    = HUNT;
          bit_cnt_d  = '0;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + 8'd1;
        end
      end
      default: state_d = HUNT;
    endcase

    // Output hold register: a new byte may replace the held one only if the
    // consumer takes the held one in the same cycle.
    if (byte_done) begin
      if (!data_valid_q || ready) begin
        data_out_d   = sr_d;
        data_valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (ready) begin
      data_valid_d = 1'b0;
    end

    // A new overrun wins over a coincident clear.
    overrun_d = ovr_set | (overrun_q & ~ovr_clr);
    locked_d  = (state_d == LOCKED);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      prev_line_q  <= 1'b0;
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      idle_cnt_q   <= '0;
      bit_out_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_line_q  <= prev_line_d;
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      bit_out_q    <= bit_out_d;
      bit_valid_q  <= bit_valid_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      locked_q     <= locked_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bit_out    = bit_out_q;
  assign bit_valid  = bit_valid_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign locked     = locked_q;
  assign overrun    = overrun_q;

endmodule
